// File: rtl/cache_pkg.sv
// Shared definitions for the single-line cache controller:
// line geometry, controller state encoding and the tag helper.
package cache_pkg;

    localparam int LINE_BYTES = 32;
    localparam int OFFSET_W   = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL,
        MEM_WR,
        RESP
    } state_e;

    // Tag of a byte address; callers truncate to their tag width.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr);
        return addr >> OFFSET_W;
    endfunction

endpackage

// File: rtl/cache_ben_dec.sv
// Byte-enable decoder for the 32-byte data array.
// Ports: en gates the output, fill_mode selects a beat-wide run of
// MEM_W/8 bytes at beat*(MEM_W/8), else a one-hot byte at offset.
module cache_ben_dec
    import cache_pkg::*;
#(
    parameter int MEM_W  = 32,
    parameter int BEAT_W = 3
) (
    input  logic                  en,
    input  logic                  fill_mode,
    input  logic [OFFSET_W-1:0]   offset,
    input  logic [BEAT_W-1:0]     beat,
    output logic [LINE_BYTES-1:0] dec
);

    localparam int BPB = MEM_W / 8;
    // 64-bit intermediate so a full-line beat (BPB=32) yields all ones.
    localparam logic [LINE_BYTES-1:0] BEAT_MASK =
        LINE_BYTES'((64'd1 << BPB) - 64'd1);

    always_comb begin
        dec = '0;
        if (en) begin
            if (fill_mode) begin
                dec = BEAT_MASK << (int'(beat) * BPB);
            end else begin
                dec = LINE_BYTES'(1) << offset;
            end
        end
    end

endmodule

// File: rtl/cache_line_ctrl.sv
// Single-line write-through, no-write-allocate cache controller.
// Ports: CPU byte req/ready, memory fill/write-through, data array strobes.
module cache_line_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int MEM_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ready,
    output logic [7:0]        cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [MEM_W-1:0]  mem_rdata,
    output logic              arr_regWrite,
    output logic [31:0]       arr_decOut,
    output logic [255:0]      arr_wdata,
    input  logic [255:0]      arr_rdata
);

    localparam int TAG_W  = ADDR_W - OFFSET_W;
    localparam int BEATS  = 256 / MEM_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          rdata_q, rdata_d;

    logic                dec_en;
    logic                dec_fill;
    logic [OFFSET_W-1:0] offset;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic [7:0]          rd_byte;

    assign offset  = addr_q[OFFSET_W-1:0];
    assign req_tag = TAG_W'(addr_tag(32'(addr_q)));
    assign hit     = valid_q && (tag_q == req_tag);
    assign rd_byte = arr_rdata[{offset, 3'b000} +: 8];

    cache_ben_dec #(
        .MEM_W (MEM_W),
        .BEAT_W(BEAT_W)
    ) u_ben_dec (
        .en       (dec_en),
        .fill_mode(dec_fill),
        .offset   (offset),
        .beat     (beat_q),
        .dec      (arr_decOut)
    );

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cpu_ready    = 1'b0;
        cpu_rdata    = rdata_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        arr_regWrite = 1'b0;
        arr_wdata    = '0;
        dec_en       = 1'b0;
        dec_fill     = 1'b0;
        // Outputs are forced quiet while reset is held so a reset that
        // lands mid-fill cannot let a late beat reach the array.
        if (reset) begin
            cpu_rdata = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (flush) valid_d = 1'b0;
                    if (cpu_req) begin
                        addr_d  = cpu_addr;
                        we_d    = cpu_we;
                        wdata_d = cpu_wdata;
                        state_d = LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (we_q) begin
                        if (hit) begin
                            arr_regWrite = 1'b1;
                            dec_en       = 1'b1;
                            arr_wdata    = {32{wdata_q}};
                        end
                        state_d = MEM_WR;
                    end else begin
                        state_d = hit ? RESP : FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    mem_req  = 1'b1;
                    mem_addr = {addr_q[ADDR_W-1:OFFSET_W],
                                {OFFSET_W{1'b0}}};
                    beat_d   = '0;
                    // Line is about to be partially overwritten.
                    valid_d  = 1'b0;
                    state_d  = FILL;
                end
                FILL: begin
                    if (mem_rvalid) begin
                        arr_regWrite = 1'b1;
                        dec_en       = 1'b1;
                        dec_fill     = 1'b1;
                        arr_wdata    = {BEATS{mem_rdata}};
                        if (beat_q == LAST_BEAT) begin
                            valid_d = 1'b1;
                            tag_d   = req_tag;
                            state_d = RESP;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                MEM_WR: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                    if (mem_ack) state_d = RESP;
                end
                RESP: begin
                    cpu_ready = 1'b1;
                    if (!we_q) begin
                        rdata_d   = rd_byte;
                        cpu_rdata = rd_byte;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            tag_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench for cache_line_ctrl with a behavioural 32-byte array.
// Vectors are hand-computed; all checks go through check().
module tb_cache_line_ctrl;

    localparam int ADDR_W = 16;
    localparam int MEM_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ready;
    logic [7:0]        cpu_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [MEM_W-1:0]  mem_rdata;
    logic              arr_regWrite;
    logic [31:0]       arr_decOut;
    logic [255:0]      arr_wdata;
    logic [255:0]      arr_rdata;

    logic [7:0] line_arr [32];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_line_ctrl #(
        .ADDR_W(ADDR_W),
        .MEM_W (MEM_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .arr_regWrite(arr_regWrite),
        .arr_decOut  (arr_decOut),
        .arr_wdata   (arr_wdata),
        .arr_rdata   (arr_rdata)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (arr_regWrite && arr_decOut[i])
                line_arr[i] <= arr_wdata[8*i +: 8];
        end
    end

    always_comb begin
        arr_rdata = '0;
        for (int i = 0; i < 32; i++)
            arr_rdata[8*i +: 8] = line_arr[i];
    end

    task automatic check(input string tag,
                         input logic [255:0] got,
                         input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE; returns with the controller in LOOKUP.
    task automatic issue(input logic we, input logic [15:0] a,
                         input logic [7:0] d, input logic fl);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        flush     = fl;
        step();
        cpu_req = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic drive_beat(input int k, input logic [7:0] base);
        mem_rvalid = 1'b1;
        for (int j = 0; j < 4; j++)
            mem_rdata[8*j +: 8] = base + 8'(4*k + j);
    endtask

    // Called in LOOKUP of a read miss; returns in RESP.
    task automatic fill(input logic [15:0] line,
                        input logic [7:0] base, input int gap_at);
        logic [31:0] mask;
        step();
        #1;
        check("fill_req", mem_req, 1'b1);
        check("fill_we", mem_we, 1'b0);
        check("fill_addr", mem_addr, line);
        step();
        for (int k = 0; k < 8; k++) begin
            if (k == gap_at) begin
                mem_rvalid = 1'b0;
                #1;
                check("gap_wr", arr_regWrite, 1'b0);
                check("gap_dec", arr_decOut, 32'h0);
                step();
            end
            drive_beat(k, base);
            #1;
            mask = 32'hF << (4*k);
            check("beat_wr", arr_regWrite, 1'b1);
            check("beat_dec", arr_decOut, mask);
            check("beat_rdy", cpu_ready, 1'b0);
            step();
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_rdy", cpu_ready, 1'b0);
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_mreq", mem_req, 1'b0);
        check("rst_maddr", mem_addr, 16'h0);
        check("rst_wr", arr_regWrite, 1'b0);
        check("rst_dec", arr_decOut, 32'h0);
        step();

        // read miss 0x1234, line bytes 0x00..0x1F, with a stall beat
        issue(1'b0, 16'h1234, 8'h00, 1'b0);
        #1;
        check("miss_lookup_mreq", mem_req, 1'b0);
        fill(16'h1220, 8'h00, 3);
        #1;
        check("miss_rdy", cpu_ready, 1'b1);
        check("miss_rdata", cpu_rdata, 8'h14);
        step();
        #1;
        check("miss_rdy_drop", cpu_ready, 1'b0);

        // read hit 0x123F, ready 2 cycles after request
        issue(1'b0, 16'h123F, 8'h00, 1'b0);
        #1;
        check("hit_c1_rdy", cpu_ready, 1'b0);
        check("hit_c1_mreq", mem_req, 1'b0);
        step();
        #1;
        check("hit_rdy", cpu_ready, 1'b1);
        check("hit_rdata", cpu_rdata, 8'h1F);
        check("hit_mreq", mem_req, 1'b0);
        step();
        #1;
        check("hit_rdy_drop", cpu_ready, 1'b0);
        check("hit_rdata_hold", cpu_rdata, 8'h1F);

        // write hit 0xA5 -> 0x1221, ack on third MEM_WR cycle
        issue(1'b1, 16'h1221, 8'hA5, 1'b0);
        #1;
        check("wh_wr", arr_regWrite, 1'b1);
        check("wh_dec", arr_decOut, 32'h0000_0002);
        check("wh_wdata", arr_wdata, {32{8'hA5}});
        step();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) mem_ack = 1'b1;
            #1;
            check("wh_mreq", mem_req, 1'b1);
            check("wh_mwe", mem_we, 1'b1);
            check("wh_maddr", mem_addr, 16'h1221);
            check("wh_mwdata", mem_wdata, 8'hA5);
            check("wh_arr_idle", arr_regWrite, 1'b0);
            check("wh_rdy_wait", cpu_ready, 1'b0);
            step();
        end
        mem_ack = 1'b0;
        #1;
        check("wh_rdy", cpu_ready, 1'b1);
        check("wh_rdata_hold", cpu_rdata, 8'h1F);
        step();
        issue(1'b0, 16'h1221, 8'h00, 1'b0);
        step();
        #1;
        check("wh_rb_rdy", cpu_ready, 1'b1);
        check("wh_rb_rdata", cpu_rdata, 8'hA5);
        step();

        // write miss 0x5A -> 0x4000, no allocate
        issue(1'b1, 16'h4000, 8'h5A, 1'b0);
        #1;
        check("wm_wr", arr_regWrite, 1'b0);
        step();
        mem_ack = 1'b1;
        #1;
        check("wm_mreq", mem_req, 1'b1);
        check("wm_mwe", mem_we, 1'b1);
        check("wm_maddr", mem_addr, 16'h4000);
        check("wm_mwdata", mem_wdata, 8'h5A);
        step();
        mem_ack = 1'b0;
        #1;
        check("wm_rdy", cpu_ready, 1'b1);
        step();
        issue(1'b0, 16'h1221, 8'h00, 1'b0);
        #1;
        check("wm_rb_mreq", mem_req, 1'b0);
        step();
        #1;
        check("wm_rb_rdy", cpu_ready, 1'b1);
        check("wm_rb_rdata", cpu_rdata, 8'hA5);
        step();

        // flush with a same-cycle read: forced miss and refill
        issue(1'b0, 16'h1221, 8'h00, 1'b1);
        fill(16'h1220, 8'h00, 8);
        #1;
        check("fl_rdy", cpu_ready, 1'b1);
        check("fl_rdata", cpu_rdata, 8'h01);
        step();

        // reset after beat 3 of a fill to 0x1200
        issue(1'b0, 16'h1200, 8'h00, 1'b0);
        step();
        #1;
        check("rf_addr", mem_addr, 16'h1200);
        step();
        for (int k = 0; k < 4; k++) begin
            drive_beat(k, 8'h40);
            step();
        end
        reset = 1'b1;
        drive_beat(4, 8'h40);
        #1;
        check("rf_rst_wr", arr_regWrite, 1'b0);
        check("rf_rst_rdy", cpu_ready, 1'b0);
        step();
        reset = 1'b0;
        for (int k = 5; k < 8; k++) begin
            drive_beat(k, 8'h40);
            #1;
            check("rf_late_wr", arr_regWrite, 1'b0);
            check("rf_late_rdy", cpu_ready, 1'b0);
            check("rf_late_mreq", mem_req, 1'b0);
            step();
        end
        mem_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("rf_idle_rdy", cpu_ready, 1'b0);
            step();
        end
        issue(1'b0, 16'h1200, 8'h00, 1'b0);
        fill(16'h1200, 8'h40, 8);
        #1;
        check("rf_rdy", cpu_ready, 1'b1);
        check("rf_rdata", cpu_rdata, 8'h40);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_line_ctrl.md
Name: cache_line_ctrl

Overview:
- Controller that sequences the 32-byte cache data array (32 x 8-bit byte registers, one 256-bit line).
- Holds line tag and valid bit.
- Serves byte reads and writes from a single CPU-side requester.
- Refills the line from memory in MEM_W-bit beats, driving the array's regWrite and 32-bit byte-select (decOut) bus.
- Write-through, no-write-allocate. Sits between the CPU load/store stage and the memory interface.

Parameters:
- ADDR_W, 16, byte address width. Tag = ADDR_W-5 bits, offset = 5 bits.
- MEM_W, 32, memory read beat width. Legal values: 8, 32, 64, 128, 256. BEATS = 256/MEM_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  clear line valid bit (acted on only in IDLE).
- cpu_req  in  1  request strobe, one-cycle pulse.
- cpu_we  in  1  1 = byte write, 0 = byte read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  8  write byte.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read byte, valid with cpu_ready, held otherwise.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = byte write-through, 0 = line fill.
- mem_addr  out  ADDR_W  line address for fill (offset = 0); byte address for write.
- mem_wdata  out  8  write-through byte.
- mem_ack  in  1  write accepted.
- mem_rvalid  in  1  fill beat valid.
- mem_rdata  in  MEM_W  fill beat data.
- arr_regWrite  out  1  data array write strobe.
- arr_decOut  out  32  byte-register select, bit i enables byte i.
- arr_wdata  out  256  data array write data.
- arr_rdata  in  256  data array contents.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state = IDLE, valid = 0, tag = 0, beat counter = 0. All outputs 0, including cpu_rdata.
- States:
  - IDLE: on cpu_req, latch addr/we/wdata and go to LOOKUP.
  - LOOKUP: hit = valid && tag == addr[ADDR_W-1:5].
    - Read hit -> RESP.
    - Read miss -> FILL_REQ.
    - Write hit -> drive array write this cycle, then -> MEM_WR.
    - Write miss -> MEM_WR.
  - FILL_REQ: mem_req=1, mem_we=0, mem_addr = {tag,5'b0} for one cycle; beat counter cleared -> FILL.
  - FILL: on each mem_rvalid, beat k writes mem_rdata byte j to array byte k*(MEM_W/8)+j (little-endian).
    - arr_regWrite=1; arr_decOut has MEM_W/8 contiguous bits set.
    - On the last beat (k = BEATS-1): valid<=1, tag<=latched tag -> RESP.
    - Cycles without mem_rvalid: arr_regWrite=0 and no state change.
  - MEM_WR: mem_req=1, mem_we=1, mem_addr/mem_wdata held until the cycle mem_ack=1 -> RESP.
  - RESP: cpu_ready=1 for one cycle.
    - Reads: cpu_rdata <= arr_rdata[8*off +: 8].
    - Writes: cpu_rdata unchanged.
    - Next state IDLE.
- Write-hit array write: arr_regWrite=1, arr_decOut one-hot at offset, arr_wdata = cpu_wdata replicated 32x.
- arr_decOut is all-zero whenever arr_regWrite=0.
- Latency, counted in cycles after the cpu_req cycle:
  - Read hit: cpu_ready in cycle 2.
  - Read miss: cpu_ready 1 cycle after the last fill beat's RESP entry.
  - Write: cpu_ready in the cycle after mem_ack.
- cpu_req outside IDLE is ignored, with no queueing. The requester waits for cpu_ready before the next request.
- flush && cpu_req in the same IDLE cycle: valid cleared first; the request proceeds and sees a miss.
- flush outside IDLE is ignored.
- mem_rvalid outside FILL and mem_ack outside MEM_WR are ignored.
- Reset mid-fill or mid-write returns to IDLE with valid=0. Beats arriving later are ignored.
- The beat counter is $clog2(BEATS) bits, minimum 1, and does not wrap during a fill.

Decomposition:
- Package cache_pkg holds:
  - LINE_BYTES=32, OFFSET_W=5.
  - The state enum {IDLE, LOOKUP, FILL_REQ, FILL, MEM_WR, RESP}.
  - A function returning tag from address.
- One sub-module: cache_ben_dec (mode, offset, beat index -> 32-bit arr_decOut), combinational.

Test Plan:
- Reset, then read 0x1234: miss; FILL_REQ with mem_addr=0x1220; 8 beats with bytes 0x00..0x1F -> cpu_ready, cpu_rdata=0x14, valid=1.
- Read 0x123F after fill -> cpu_ready exactly 2 cycles after cpu_req, cpu_rdata=0x1F, mem_req stays 0.
- Write 0xA5 to 0x1221 (hit) -> arr_decOut=0x00000002 with arr_regWrite for one cycle; mem_req/mem_we held 3 cycles until mem_ack; then reading 0x1221 returns 0xA5.
- Write 0x5A to 0x4000 (miss) -> no arr_regWrite, mem write issued, tag unchanged; reading 0x1221 still hits.
- flush with cpu_req read 0x1221 in the same cycle -> miss, new fill issued to 0x1220.
- Reset asserted after beat 3 of a fill, remaining beats still driven -> no arr_regWrite, valid=0, cpu_ready never pulses; the next read of 0x1200 misses.
